mem_access_stage: RTL

Memory stage of the sequential Y86-64 core, directly upstream of write-back. It performs the data-memory access selected by `icode` against an internal byte-addressable data memory through a byte-serial port: one byte per clock, little-endian. It produces `valM` and a memory-error flag for write-back, plus a `done` strobe so the sequencer knows when to clock write-back and PC update.

---
 rtl/mem_access_stage.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Y86-64 memory stage: byte-serial, little-endian access to an internal data memory,
// returning valM and dmem_error to write-back with a one-cycle done strobe.
module mem_access_stage #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        done,
    output logic        busy
);

    localparam int unsigned AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      cnt;
    logic [AW-1:0]   addr_q;
    logic [63:0]     wdata_q;
    logic [63:0]     acc;
    logic [63:0]     acc_next;
    logic [7:0]      mem [MEM_BYTES];

    logic            is_rd_c;
    logic            is_wr_c;
    logic            range_err_c;
    logic [63:0]     req_addr_c;
    logic [AW-1:0]   byte_idx_c;

    // Access decode, range check and next-state logic
    always_comb begin
        is_rd_c     = (icode == 4'd5) || (icode == 4'd9) || (icode == 4'd11);
        is_wr_c     = (icode == 4'd4) || (icode == 4'd8) || (icode == 4'd10);
        req_addr_c  = ((icode == 4'd9) || (icode == 4'd11)) ? valA : valE;
        // Full 64-bit compare so huge addresses cannot wrap into range
        range_err_c = (is_rd_c || is_wr_c) && (req_addr_c > LAST_ADDR);
        byte_idx_c  = addr_q + AW'(cnt);
        acc_next    = acc;
        state_next  = state;

        if (state == READ) begin
            acc_next[{cnt, 3'b000} +: 8] = mem[byte_idx_c];
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (!(is_rd_c || is_wr_c) || range_err_c) begin
                        state_next = DONE;
                    end else if (is_rd_c) begin
                        state_next = READ;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            READ, WRITE: begin
                if (cnt == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
            acc        <= 64'd0;
            valM       <= 64'd0;
            dmem_error <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
            busy  <= (state_next != IDLE);

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= 3'd0;
                        acc     <= 64'd0;
                        addr_q  <= req_addr_c[AW-1:0];
                        wdata_q <= (icode == 4'd8) ? valP : valA;
                    end
                end
                READ: begin
                    acc <= acc_next;
                    cnt <= cnt + 3'd1;
                end
                WRITE: begin
                    cnt <= cnt + 3'd1;
                end
                default: begin
                end
            endcase

            // Results only change on entry to DONE
            if (state_next == DONE) begin
                valM       <= (state == READ) ? acc_next : 64'd0;
                dmem_error <= (state == IDLE) && range_err_c;
            end
        end
    end

    // Data memory: uninitialised and untouched by reset
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            mem[byte_idx_c] <= wdata_q[{cnt, 3'b000} +: 8];
        end
    end

endmodule
